// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz game control unit.
// State codes and the per-player score slice helper.
`define QUIZ_PONTOS(v, i, w) v[(i)*(w) +: (w)]

package quiz_pkg;
    localparam logic [3:0] S_INICIAL  = 4'd0;
    localparam logic [3:0] S_MOSTRA   = 4'd2;
    localparam logic [3:0] S_ESPERA   = 4'd3;
    localparam logic [3:0] S_REGISTRA = 4'd4;
    localparam logic [3:0] S_COMPARA  = 4'd5;
    localparam logic [3:0] S_PROXIMA  = 4'd6;
    localparam logic [3:0] S_APURA    = 4'd7;
    localparam logic [3:0] S_FIM      = 4'd15;
endpackage

// File: rtl/arbitro_prioridade.sv
// Combinational lowest-index select over the eligible buzzers.
module arbitro_prioridade #(
    parameter int N  = 2,
    parameter int WI = 1
) (
    input  logic [N-1:0]  i_cand,
    output logic [WI-1:0] o_idx,
    output logic          o_valido
);
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_cand[i]) o_idx = WI'(i);
        end
    end

    assign o_valido = |i_cand;
endmodule

// File: rtl/unidade_controle_quiz.sv
// Control unit for the multi-player quiz: rounds, buzzer window,
// lock-out, saturating scores and winner selection.
module unidade_controle_quiz
    import quiz_pkg::*;
#(
    parameter int N_JOGADORES = 2,
    parameter int N_RODADAS   = 8,
    parameter int T_MOSTRA    = 1000,
    parameter int T_RESPOSTA  = 5000,
    parameter int W_PONTOS    = 4,
    localparam int WJ = (N_JOGADORES > 1) ? $clog2(N_JOGADORES) : 1,
    localparam int WR = (N_RODADAS > 1) ? $clog2(N_RODADAS) : 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            iniciar,
    input  logic [N_JOGADORES-1:0]          jogada,
    input  logic                            igual,
    output logic                            registraR,
    output logic                            mostra,
    output logic [WR-1:0]                   rodada,
    output logic [WJ-1:0]                   jogador_vez,
    output logic [N_JOGADORES-1:0]          bloqueados,
    output logic [N_JOGADORES*W_PONTOS-1:0] pontos,
    output logic                            acertou,
    output logic                            errou,
    output logic                            pronto,
    output logic [WJ-1:0]                   vencedor,
    output logic                            empate,
    output logic [3:0]                      db_estado
);
    localparam int T_MAX = (T_MOSTRA > T_RESPOSTA) ? T_MOSTRA : T_RESPOSTA;
    localparam int WT    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int NP    = N_JOGADORES * W_PONTOS;

    logic [3:0]             r_estado;
    logic [WT-1:0]          r_timer;
    logic [WR-1:0]          r_rodada;
    logic [WJ-1:0]          r_jogador;
    logic [N_JOGADORES-1:0] r_bloq;
    logic [NP-1:0]          r_pontos;
    logic [WJ-1:0]          r_vencedor;
    logic                   r_empate;

    logic [N_JOGADORES-1:0] w_cand;
    logic [WJ-1:0]          w_idx;
    logic                   w_valido;
    logic                   w_fim_mostra;
    logic                   w_fim_resp;
    logic                   w_ultima;
    logic [N_JOGADORES-1:0] w_sel;
    logic [N_JOGADORES-1:0] w_bloq_novo;
    logic [NP-1:0]          w_pontos_inc;
    logic [W_PONTOS-1:0]    w_max;
    logic [WJ-1:0]          w_venc;
    logic                   w_empate;

    assign w_cand = jogada & ~r_bloq;

    arbitro_prioridade #(
        .N  (N_JOGADORES),
        .WI (WJ)
    ) u_arbitro (
        .i_cand   (w_cand),
        .o_idx    (w_idx),
        .o_valido (w_valido)
    );

    assign w_fim_mostra = (r_timer == WT'(T_MOSTRA - 1));
    assign w_fim_resp   = (r_timer == WT'(T_RESPOSTA - 1));
    assign w_ultima     = (r_rodada == WR'(N_RODADAS - 1));
    assign w_bloq_novo  = r_bloq | w_sel;

    always_comb begin
        w_sel        = '0;
        w_pontos_inc = r_pontos;
        for (int i = 0; i < N_JOGADORES; i++) begin
            w_sel[i] = (WJ'(i) == r_jogador);
            if (w_sel[i] && (`QUIZ_PONTOS(r_pontos, i, W_PONTOS) != '1))
                `QUIZ_PONTOS(w_pontos_inc, i, W_PONTOS) =
                    `QUIZ_PONTOS(r_pontos, i, W_PONTOS) + 1'b1;
        end
    end

    // Strict '>' keeps the lowest index on a tie for the maximum.
    always_comb begin
        w_max    = '0;
        w_venc   = '0;
        w_empate = 1'b0;
        for (int i = 0; i < N_JOGADORES; i++) begin
            if (`QUIZ_PONTOS(r_pontos, i, W_PONTOS) > w_max) begin
                w_max  = `QUIZ_PONTOS(r_pontos, i, W_PONTOS);
                w_venc = WJ'(i);
            end
        end
        for (int i = 0; i < N_JOGADORES; i++) begin
            if ((`QUIZ_PONTOS(r_pontos, i, W_PONTOS) == w_max) &&
                (WJ'(i) != w_venc))
                w_empate = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado   <= S_INICIAL;
            r_timer    <= '0;
            r_rodada   <= '0;
            r_jogador  <= '0;
            r_bloq     <= '0;
            r_pontos   <= '0;
            r_vencedor <= '0;
            r_empate   <= 1'b0;
        end else begin
            case (r_estado)
                S_INICIAL: begin
                    r_timer    <= '0;
                    r_rodada   <= '0;
                    r_bloq     <= '0;
                    r_pontos   <= '0;
                    r_vencedor <= '0;
                    r_empate   <= 1'b0;
                    if (iniciar) r_estado <= S_MOSTRA;
                end
                S_MOSTRA: begin
                    if (w_fim_mostra) begin
                        r_timer  <= '0;
                        r_estado <= S_ESPERA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_ESPERA: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_valido) begin
                        r_jogador <= w_idx;
                        r_estado  <= S_REGISTRA;
                    end else if (w_fim_resp) begin
                        r_estado <= S_PROXIMA;
                    end
                end
                S_REGISTRA: r_estado <= S_COMPARA;
                S_COMPARA: begin
                    if (igual) begin
                        r_pontos <= w_pontos_inc;
                        r_estado <= S_PROXIMA;
                    end else begin
                        r_bloq <= w_bloq_novo;
                        if (&w_bloq_novo) begin
                            r_estado <= S_PROXIMA;
                        end else begin
                            r_timer  <= '0;
                            r_estado <= S_ESPERA;
                        end
                    end
                end
                S_PROXIMA: begin
                    r_bloq  <= '0;
                    r_timer <= '0;
                    if (w_ultima) begin
                        r_estado <= S_APURA;
                    end else begin
                        r_rodada <= r_rodada + 1'b1;
                        r_estado <= S_MOSTRA;
                    end
                end
                S_APURA: begin
                    r_vencedor <= w_venc;
                    r_empate   <= w_empate;
                    r_estado   <= S_FIM;
                end
                S_FIM: begin
                    if (iniciar) r_estado <= S_INICIAL;
                end
                default: r_estado <= S_INICIAL;
            endcase
        end
    end

    assign registraR   = (r_estado == S_REGISTRA);
    assign mostra      = (r_estado == S_MOSTRA);
    assign acertou     = (r_estado == S_COMPARA) && igual;
    assign errou       = (r_estado == S_COMPARA) && !igual;
    assign pronto      = (r_estado == S_FIM);
    assign rodada      = r_rodada;
    assign jogador_vez = r_jogador;
    assign bloqueados  = r_bloq;
    assign pontos      = r_pontos;
    assign vencedor    = r_vencedor;
    assign empate      = r_empate;
    assign db_estado   = r_estado;
endmodule

// File: tb/tb_unidade_controle_quiz.sv
// Directed bench for the quiz control unit (2 players, 5 rounds).
module tb_unidade_controle_quiz;
    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [1:0] jogada;
    logic       igual;
    logic       registraR;
    logic       mostra;
    logic [2:0] rodada;
    logic       jogador_vez;
    logic [1:0] bloqueados;
    logic [3:0] pontos;
    logic       acertou;
    logic       errou;
    logic       pronto;
    logic       vencedor;
    logic       empate;
    logic [3:0] db_estado;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt;

    unidade_controle_quiz #(
        .N_JOGADORES (2),
        .N_RODADAS   (5),
        .T_MOSTRA    (4),
        .T_RESPOSTA  (8),
        .W_PONTOS    (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .jogada      (jogada),
        .igual       (igual),
        .registraR   (registraR),
        .mostra      (mostra),
        .rodada      (rodada),
        .jogador_vez (jogador_vez),
        .bloqueados  (bloqueados),
        .pontos      (pontos),
        .acertou     (acertou),
        .errou       (errou),
        .pronto      (pronto),
        .vencedor    (vencedor),
        .empate      (empate),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_estado(input logic [3:0] s, input int lim);
        int k;
        k = 0;
        while (db_estado !== s && k < lim) begin
            step();
            k++;
        end
        chk("wait_estado", 32'(db_estado), 32'(s));
    endtask

    task automatic vence(input logic [1:0] quem);
        wait_estado(4'd3, 20);
        jogada = quem;
        igual  = 1'b1;
        step();
        jogada = 2'b00;
        step();
        step();
    endtask

    task automatic dois_inicios();
        iniciar = 1'b1;
        step();
        step();
        iniciar = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        jogada  = 2'b00;
        igual   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_outs", 32'({registraR, mostra, rodada, jogador_vez,
            bloqueados, pontos, acertou, errou, pronto, vencedor, empate,
            db_estado}), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_no_start", 32'(db_estado), 32'd0);

        // Round 0: player 1 answers right
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        cnt = 0;
        while (mostra === 1'b1 && cnt < 20) begin
            cnt++;
            step();
        end
        chk("mostra_len", 32'(cnt), 32'd4);
        chk("espera_after_mostra", 32'(db_estado), 32'd3);
        jogada = 2'b10;
        igual  = 1'b1;
        step();
        jogada = 2'b00;
        chk("registraR", 32'(registraR), 32'd1);
        chk("vez_p1", 32'(jogador_vez), 32'd1);
        step();
        chk("acertou", 32'({acertou, errou}), 32'b10);
        step();
        chk("pontos_r0", 32'(pontos), 32'b0100);
        step();
        chk("rodada1", 32'(rodada), 32'd1);

        // Round 1: simultaneous buzz, lowest index wins
        wait_estado(4'd3, 20);
        jogada = 2'b11;
        step();
        jogada = 2'b00;
        chk("vez_tie", 32'(jogador_vez), 32'd0);
        step();
        step();
        chk("pontos_r1", 32'(pontos), 32'b0101);
        step();

        // Round 2: player 0 wrong and locked out, player 1 right
        wait_estado(4'd3, 20);
        jogada = 2'b01;
        igual  = 1'b0;
        step();
        jogada = 2'b00;
        step();
        chk("errou_r2", 32'({acertou, errou}), 32'b01);
        step();
        chk("mask_01", 32'(bloqueados), 32'b01);
        chk("back_espera", 32'(db_estado), 32'd3);
        jogada = 2'b01;
        step();
        chk("locked_ignored", 32'(db_estado), 32'd3);
        jogada = 2'b10;
        igual  = 1'b1;
        step();
        jogada = 2'b00;
        chk("vez_after_lock", 32'(jogador_vez), 32'd1);
        step();
        step();
        chk("pontos_r2", 32'(pontos), 32'b1001);
        step();
        chk("mask_cleared", 32'(bloqueados), 32'b00);

        // Round 3: buzz on final window cycle, then full timeout
        wait_estado(4'd3, 20);
        repeat (7) step();
        jogada = 2'b10;
        igual  = 1'b0;
        step();
        jogada = 2'b00;
        chk("last_cycle_buzz", 32'(db_estado), 32'd4);
        step();
        chk("errou_r3", 32'(errou), 32'd1);
        step();
        chk("mask_10", 32'(bloqueados), 32'b10);
        cnt = 0;
        while (db_estado === 4'd3 && cnt < 20) begin
            cnt++;
            step();
        end
        chk("window_len", 32'(cnt), 32'd8);
        chk("timeout_proxima", 32'(db_estado), 32'd6);
        chk("pontos_r3", 32'(pontos), 32'b1001);

        // Round 4 (last): both wrong, then result
        wait_estado(4'd3, 20);
        jogada = 2'b01;
        igual  = 1'b0;
        step();
        jogada = 2'b00;
        step();
        step();
        jogada = 2'b10;
        step();
        jogada = 2'b00;
        step();
        chk("errou_second", 32'(errou), 32'd1);
        step();
        chk("all_locked_proxima", 32'({bloqueados, db_estado}), 32'h36);
        step();
        chk("apura_mask0", 32'({bloqueados, db_estado}), 32'h07);
        step();
        chk("fim_result", 32'({pronto, vencedor, empate, db_estado}),
            32'h6F);
        step();
        chk("fim_hold", 32'({pontos, pronto}), 32'b10011);

        // Game 2: saturation of player 1
        dois_inicios();
        chk("restart_clear", 32'({pontos, rodada, db_estado}),
            32'h002);
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk("iniciar_ignored", 32'(db_estado), 32'd2);
        repeat (4) vence(2'b10);
        chk("saturated", 32'(pontos[3:2]), 32'd3);
        wait_estado(4'd15, 40);
        chk("g2_pontos", 32'(pontos), 32'b1100);

        // Game 3: all timeouts, tie at zero
        dois_inicios();
        wait_estado(4'd15, 100);
        chk("tie_result", 32'({pronto, vencedor, empate}), 32'b101);

        // Reset during MOSTRA
        dois_inicios();
        step();
        chk("mostra_before_rst", 32'(mostra), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_reset", 32'({registraR, mostra, rodada, jogador_vez,
            bloqueados, pontos, acertou, errou, pronto, vencedor, empate,
            db_estado}), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("post_reset_idle", 32'(db_estado), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
